// File: rtl/imem_fill_responder.sv
// Instruction-cache line-fill responder: reads BLOCKS words from backing memory and returns them as beats.
// Critical-word-first wrapping order is enabled by defining RV_ICACHE_CRITWORD_EN.
module imem_fill_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCKS     = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_req_valid,
  input  logic [ADDR_WIDTH-1:0]     i_req_addr,
  output logic                      o_req_ready,
  output logic                      o_mem_rd,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_rsp_data,
  output logic [$clog2(BLOCKS)-1:0] o_rsp_index,
  output logic                      o_rsp_last
);
  localparam int IDXW = $clog2(BLOCKS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(BLOCKS * 4 - 1);
  localparam logic [IDXW:0]         LAST_K    = (IDXW + 1)'(BLOCKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;
  state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDXW-1:0]       r_start;
  logic [IDXW:0]         r_issued;
  logic                  r_inflight;
  logic [IDXW-1:0]       r_fly_idx;
  logic                  r_fly_last;

  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [IDXW-1:0]       r_fifo_idx  [2];
  logic                  r_fifo_last [2];
  logic                  r_wr_ptr, r_rd_ptr;
  logic [1:0]            r_count;

  logic            w_accept, w_mem_rd, w_pop, w_push, w_rsp_valid, w_credit_ok, w_head_last;
  logic [IDXW-1:0] w_rd_idx, w_start;

`ifdef RV_ICACHE_CRITWORD_EN
  assign w_start = i_req_addr[IDXW+1:2];
`else
  assign w_start = '0;
`endif

  assign w_rd_idx    = r_start + r_issued[IDXW-1:0];
  assign w_rsp_valid = (r_count != 2'd0) && !i_reset;
  assign w_pop       = w_rsp_valid && i_rsp_ready;
  assign w_push      = r_inflight;
  assign w_accept    = o_req_ready && i_req_valid;
  assign w_head_last = r_fifo_last[r_rd_ptr];
  // Reserve FIFO space for every read in flight; the beat leaving this cycle frees a slot.
  assign w_credit_ok = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BURST;
      S_BURST: if (w_mem_rd && r_issued == LAST_K) w_next = S_DRAIN;
      S_DRAIN: if (w_pop && w_head_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 1'b0;
    w_mem_rd    = 1'b0;
    if (!i_reset) begin
      o_req_ready = (r_state == S_IDLE);
      w_mem_rd    = (r_state == S_BURST) && w_credit_ok;
    end
    o_mem_rd    = w_mem_rd;
    o_mem_addr  = w_mem_rd ? (r_base | (ADDR_WIDTH'(w_rd_idx) << 2)) : '0;
    o_rsp_valid = w_rsp_valid;
    o_rsp_data  = w_rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
    o_rsp_index = w_rsp_valid ? r_fifo_idx[r_rd_ptr]  : '0;
    o_rsp_last  = w_rsp_valid && w_head_last;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_base     <= '0;
      r_start    <= '0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_fly_idx  <= '0;
      r_fly_last <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_accept) begin
        r_base   <= i_req_addr & ~LINE_MASK;
        r_start  <= w_start;
        r_issued <= '0;
      end else if (w_mem_rd) begin
        r_issued <= r_issued + 1'b1;
      end
      r_inflight <= w_mem_rd;
      r_fly_idx  <= w_rd_idx;
      r_fly_last <= (r_issued == LAST_K);
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push && !i_reset) begin
      r_fifo_data[r_wr_ptr] <= i_mem_rdata;
      r_fifo_idx[r_wr_ptr]  <= r_fly_idx;
      r_fifo_last[r_wr_ptr] <= r_fly_last;
    end
  end
endmodule

// File: tb/tb_imem_fill_responder.sv
// Randomized self-checking bench for imem_fill_responder against a line-fill reference model.
module tb_imem_fill_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int IW = 2;

`ifdef RV_ICACHE_CRITWORD_EN
  localparam bit CRIT = 1'b1;
  localparam logic [31:0] LAT_D [4] = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
  localparam logic [1:0]  LAT_I [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
`else
  localparam bit CRIT = 1'b0;
  localparam logic [31:0] LAT_D [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
  localparam logic [1:0]  LAT_I [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset = 1'b1;
  logic          i_req_valid = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] mdata = '0;
  logic [1:0]    rdy_mode = 2'd0;
  logic          rdy_force = 1'b1;
  logic          rdy_rand = 1'b1;
  logic          i_rsp_ready;
  logic          o_req_ready, o_mem_rd, o_rsp_valid, o_rsp_last;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_rsp_data;
  logic [IW-1:0] o_rsp_index;

  assign i_rsp_ready = (rdy_mode == 2'd0) ? 1'b1 : (rdy_mode == 2'd1) ? rdy_rand : rdy_force;

  imem_fill_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCKS(BL)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .o_req_ready(o_req_ready), .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(mdata), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_index(o_rsp_index), .o_rsp_last(o_rsp_last)
  );

  // Backing memory: word(a) = a, one-cycle read latency; junk when not reading.
  always @(posedge clk) mdata <= o_mem_rd ? o_mem_addr : $urandom;

  initial forever begin
    @(posedge clk);
    #1 rdy_rand = ($urandom_range(0, 3) != 0);
  end

  int n_cmp = 0;
  int n_mis = 0;
  int n_beats = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;
  beat_t exp_q[$];

  function automatic beat_t model_beat(input logic [AW-1:0] a, input int k);
    beat_t b;
    int unsigned base, start, idx;
    base  = a - (a % (BL * 4));
    start = CRIT ? (a / 4) % BL : 0;
    idx   = (start + k) % BL;
    b.d = base + idx * 4;
    b.i = IW'(idx);
    b.l = (k == BL - 1);
    return b;
  endfunction

  // Monitor: scoreboard, read addresses, credit limit, stall stability, reset outputs.
  initial begin
    logic [AW-1:0] cur_addr;
    int rd_k, issued, popped;
    logic stalled, pop;
    logic [DW-1:0] h_d;
    logic [IW-1:0] h_i;
    logic h_l;
    beat_t b;
    cur_addr = '0; rd_k = 0; issued = 0; popped = 0; stalled = 1'b0;
    h_d = '0; h_i = '0; h_l = 1'b0;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        chk("rst_req_ready", o_req_ready, 0);
        chk("rst_mem_rd", o_mem_rd, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_last", o_rsp_last, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        chk("rst_rsp_index", o_rsp_index, 0);
        exp_q.delete();
        issued = 0; popped = 0; rd_k = BL; stalled = 1'b0;
      end else begin
        if (i_req_valid && o_req_ready) begin
          cur_addr = i_req_addr;
          rd_k = 0;
          for (int k = 0; k < BL; k++) exp_q.push_back(model_beat(i_req_addr, k));
        end
        pop = o_rsp_valid && i_rsp_ready;
        if (o_mem_rd) begin
          chk("reads_per_line", rd_k < BL, 1);
          b = model_beat(cur_addr, rd_k);
          chk("rd_addr", o_mem_addr, b.d);
          rd_k++;
          issued++;
        end
        if (stalled) begin
          chk("hold_valid", o_rsp_valid, 1);
          chk("hold_data", o_rsp_data, h_d);
          chk("hold_index", o_rsp_index, h_i);
          chk("hold_last", o_rsp_last, h_l);
        end
        if (o_rsp_valid && exp_q.size() == 0) begin
          chk("unexpected_beat", exp_q.size(), 1);
        end else if (pop) begin
          b = exp_q.pop_front();
          chk("beat_data", o_rsp_data, b.d);
          chk("beat_index", o_rsp_index, b.i);
          chk("beat_last", o_rsp_last, b.l);
          n_beats++;
        end
        if (pop) popped++;
        if (o_mem_rd) chk("outstanding_le2", (issued - popped) <= 2, 1);
        stalled = o_rsp_valid && !i_rsp_ready;
        h_d = o_rsp_data; h_i = o_rsp_index; h_l = o_rsp_last;
      end
    end
  end

  // Waits for o_req_ready, then presents the request for exactly one (accepting) cycle.
  task automatic send_req(input logic [AW-1:0] a);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (o_req_ready) begin ok = 1'b1; break; end
    end
    chk("req_ready_wait", ok, 1);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (o_req_ready && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("idle_wait", ok, 1);
  endtask

  initial begin
    int b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;

    // Cycle-exact latency with ready held high, request 0x1008.
    rdy_mode = 2'd0;
    send_req(32'h1008);
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      chk($sformatf("lat_mem_rd_c%0d", t), o_mem_rd, (t <= 4));
      chk($sformatf("lat_rsp_valid_c%0d", t), o_rsp_valid, (t >= 3 && t <= 6));
      chk($sformatf("lat_req_ready_c%0d", t), o_req_ready, (t == 7));
      if (t >= 3 && t <= 6) begin
        chk($sformatf("lat_data_c%0d", t), o_rsp_data, LAT_D[t-3]);
        chk($sformatf("lat_index_c%0d", t), o_rsp_index, LAT_I[t-3]);
        chk($sformatf("lat_last_c%0d", t), o_rsp_last, (t == 6));
      end
    end

    // Backpressure: ready low in cycles 3..8, first beat must sit at the head.
    b0 = n_beats;
    rdy_mode = 2'd2;
    rdy_force = 1'b0;
    send_req(32'h1A04);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        chk("stall_valid", o_rsp_valid, 1);
        chk("stall_beat0", o_rsp_data, CRIT ? 32'h1A04 : 32'h1A00);
      end
    end
    @(posedge clk); #1;
    rdy_force = 1'b1;
    wait_idle();
    chk("stall_beats", n_beats - b0, 4);

    // Reset in cycle 4 of a burst, then a clean refill.
    rdy_mode = 2'd0;
    send_req(32'h4008);
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", o_req_ready, 1);
    chk("post_rst_valid", o_rsp_valid, 0);
    @(negedge clk);
    chk("post_rst_valid_c6", o_rsp_valid, 0);
    b0 = n_beats;
    send_req(32'h4008);
    wait_idle();
    chk("post_rst_beats", n_beats - b0, 4);

    // Back-to-back: second request held valid during the first burst.
    rdy_mode = 2'd1;
    begin
      bit ok = 1'b0;
      for (int n = 0; n < 200 && !o_req_ready; n++) begin @(posedge clk); #1; end
      i_req_valid = 1'b1;
      i_req_addr  = 32'h2000;
      @(posedge clk); #1;
      b0 = n_beats;
      i_req_addr = 32'h3004;
      for (int n = 0; n < 300; n++) begin
        if (o_req_ready) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      chk("b2b_second_accept", ok, 1);
      chk("b2b_first_done", n_beats - b0, 4);
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      wait_idle();
      chk("b2b_total_beats", n_beats - b0, 8);
    end

    // Random addresses with random response backpressure.
    b0 = n_beats;
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_req($urandom);
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    chk("rand_total_beats", n_beats - b0, 25 * BL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
